// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_pkg: funct3 codes, response owner and byte-lane helpers     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B, F3_BU: be_gen = 4'b0001 << off;
         F3_H, F3_HU: be_gen = 4'b0011 << off;
         F3_W:        be_gen = 4'b1111;
         default:     be_gen = 4'b0000;
      endcase
   endfunction

   // Illegal funct3 codes report as misaligned so one check covers both
   function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B, F3_BU: is_aligned = 1'b1;
         F3_H, F3_HU: is_aligned = ~off[0];
         F3_W:        is_aligned = (off == 2'b00);
         default:     is_aligned = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_lane_align: store lane replication and load extract/extend      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_lane_align
   import mem_arb_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_lanes,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      // Replication lets byte enables alone pick the destination lane
      case (st_funct3[1:0])
         2'b00:   st_lanes = {4{st_wdata[7:0]}};
         2'b01:   st_lanes = {2{st_wdata[15:0]}};
         default: st_lanes = st_wdata;
      endcase

      shifted = ld_word >> {ld_off, 3'b000};
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    ld_data = ld_word;
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ld_data = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | unified_mem_arbiter: fetch/data arbiter for one single-port memory  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic [31:0]      i_addr,
   output logic             i_ready,
   output logic             i_rvalid,
   output logic [31:0]      i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [2:0]       d_funct3,
   input  logic [31:0]      d_wdata,
   output logic             d_ready,
   output logic             d_rvalid,
   output logic [31:0]      d_rdata,
   output logic             d_err,
   output logic             m_en,
   output logic             m_we,
   output logic [3:0]       m_be,
   output logic [31:0]      m_addr,
   output logic [31:0]      m_wdata,
   input  logic [31:0]      m_rdata,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  starve_cnt;
   owner_e      resp_owner;
   logic [1:0]  resp_off;
   logic [2:0]  resp_f3;
   logic        resp_err;
   logic        resp_err_load;
   logic        grant_i, grant_d, d_legal, d_issue, live, d_load_ok;
   logic [31:0] st_lanes, ld_data;
   logic        unused_addr_bits;

   assign unused_addr_bits = &{1'b0, i_addr[1:0]};

   // Requests seen while reset is high are never granted
   assign grant_i = !reset && i_req && (!d_req || starve_cnt == LIMIT);
   assign grant_d = !reset && d_req && !grant_i;
   assign d_legal = is_aligned(d_funct3, d_addr[1:0]) && !(d_we && d_funct3[2]);
   assign d_issue = grant_d && d_legal;

   assign i_ready = grant_i;
   assign d_ready = grant_d;
   assign m_en    = grant_i || d_issue;
   assign m_we    = d_issue && d_we;

   always_comb begin
      m_be    = 4'h0;
      m_addr  = 32'd0;
      m_wdata = 32'd0;
      if (grant_i) begin
         m_be   = 4'hF;
         m_addr = {i_addr[31:2], 2'b00};
      end else if (d_issue) begin
         m_be   = be_gen(d_funct3, d_addr[1:0]);
         m_addr = {d_addr[31:2], 2'b00};
         if (d_we) m_wdata = st_lanes;
      end
   end

   mem_lane_align u_lane_align (
      .st_funct3 (d_funct3),
      .st_wdata  (d_wdata),
      .st_lanes  (st_lanes),
      .ld_funct3 (resp_f3),
      .ld_off    (resp_off),
      .ld_word   (m_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt    <= 4'd0;
         conflict_cnt  <= '0;
         resp_owner    <= OWN_NONE;
         resp_off      <= 2'd0;
         resp_f3       <= 3'd0;
         resp_err      <= 1'b0;
         resp_err_load <= 1'b0;
      end else begin
         if (!i_req || grant_i)
            starve_cnt <= 4'd0;
         else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
         if (i_req && d_req)
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         resp_owner    <= grant_i ? OWN_I : ((d_issue && !d_we) ? OWN_D : OWN_NONE);
         resp_off      <= d_addr[1:0];
         resp_f3       <= d_funct3;
         resp_err      <= grant_d && !d_legal;
         resp_err_load <= grant_d && !d_legal && !d_we;
      end
   end

   // Response state is only cleared at the reset edge, so mask it meanwhile
   assign live      = !reset;
   assign d_load_ok = live && (resp_owner == OWN_D);
   assign i_rvalid  = live && (resp_owner == OWN_I);
   assign i_rdata   = i_rvalid ? m_rdata : 32'd0;
   assign d_rvalid  = d_load_ok || (live && resp_err_load);
   assign d_rdata   = d_load_ok ? ld_data : 32'd0;
   assign d_err     = live && resp_err;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_unified_mem_arbiter: directed + random bench with reference model|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_unified_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_ready, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ready, d_rvalid, d_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [2:0]  d_funct3;
   logic        m_en, m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [31:0] conflict_cnt;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_funct3(d_funct3), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
   );

   // 4 KiB byte memory; answers reads one cycle after the strobe
   logic [7:0]  mem [0:4095];
   wire  [11:0] mem_a = {m_addr[11:2], 2'b00};

   always @(posedge clk) begin
      if (m_en && !m_we)
         m_rdata <= {mem[mem_a + 12'd3], mem[mem_a + 12'd2], mem[mem_a + 12'd1], mem[mem_a]};
      if (m_en && m_we)
         for (int k = 0; k < 4; k++)
            if (m_be[k]) mem[mem_a + 12'(k)] <= m_wdata[8*k +: 8];
   end

   int checks = 0, passes = 0, fails = 0;

   // Reference model state
   int          starve;
   logic [31:0] conf;
   logic        p_iv, p_dv, p_de;
   logic [31:0] p_iw, p_dd;

   // Observations from the latest step, and from the grant cycle of do_data
   logic        ob_i_ready, ob_d_ready, ob_m_en, ob_i_rvalid, ob_d_rvalid, ob_d_err;
   logic [31:0] ob_m_addr, ob_m_wdata, ob_i_rdata, ob_d_rdata, ob_conf;
   logic [3:0]  ob_m_be;
   logic        g_d_ready, g_m_en;
   logic [31:0] g_m_addr, g_m_wdata;
   logic [3:0]  g_m_be;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
   endfunction

   function automatic logic legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
      if (we && f3 > 3'd2) return 1'b0;
      return (int'(addr[11:0]) % size_of(f3)) == 0;
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] addr);
      logic [11:0] a;
      a = addr[11:0] & 12'hFFC;
      return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr);
      int b0, b1, v;
      b0 = int'(mem[addr[11:0]]);
      b1 = (f3[0]) ? int'(mem[addr[11:0] + 12'd1]) : 0;
      case (f3)
         3'd0: begin v = b0; if (v > 127) v -= 256; end
         3'd4: v = b0;
         3'd1: begin v = b0 + 256 * b1; if (v > 32767) v -= 65536; end
         3'd5: v = b0 + 256 * b1;
         default: return rd_word(addr);
      endcase
      return 32'(v);
   endfunction

   task automatic poke_word(input logic [11:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) mem[a + 12'(k)] <= w[8*k +: 8];
   endtask

   // One clock cycle: check everything at the negedge, then advance the model
   task automatic step();
      logic egi, egd, dleg, eiss, rv;
      int   sz;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      @(negedge clk);
      egi  = !reset && i_req && (!d_req || starve == LIMIT);
      egd  = !reset && d_req && !egi;
      dleg = legal(d_we, d_funct3, d_addr);
      eiss = egd && dleg;
      sz   = size_of(d_funct3);
      chk("i_ready", {31'd0, i_ready}, {31'd0, egi});
      chk("d_ready", {31'd0, d_ready}, {31'd0, egd});
      chk("m_en",    {31'd0, m_en},    {31'd0, egi || eiss});
      chk("m_we",    {31'd0, m_we},    {31'd0, eiss && d_we});
      if (egi) begin
         chk("fetch_m_addr", m_addr, i_addr & 32'hFFFF_FFFC);
         chk("fetch_m_be", {28'd0, m_be}, 32'hF);
      end
      if (eiss) chk("data_m_addr", m_addr, d_addr & 32'hFFFF_FFFC);
      if (eiss && d_we) begin
         ebe = (sz == 1) ? 4'(1 << d_addr[1:0]) : ((sz == 2) ? 4'(3 << d_addr[1:0]) : 4'hF);
         ewd = (sz == 1) ? d_wdata[7:0] * 32'h0101_0101 :
               ((sz == 2) ? d_wdata[15:0] * 32'h0001_0001 : d_wdata);
         chk("store_m_be", {28'd0, m_be}, {28'd0, ebe});
         chk("store_m_wdata", m_wdata, ewd);
      end
      rv = !reset;
      chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, rv && p_iv});
      chk("i_rdata",  i_rdata, (rv && p_iv) ? p_iw : 32'd0);
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, rv && p_dv});
      chk("d_rdata",  d_rdata, (rv && p_dv) ? p_dd : 32'd0);
      chk("d_err",    {31'd0, d_err}, {31'd0, rv && p_de});
      chk("conflict_cnt", conflict_cnt, conf);
      ob_i_ready = i_ready; ob_d_ready = d_ready; ob_m_en = m_en; ob_m_addr = m_addr;
      ob_m_be = m_be; ob_m_wdata = m_wdata; ob_i_rvalid = i_rvalid; ob_i_rdata = i_rdata;
      ob_d_rvalid = d_rvalid; ob_d_rdata = d_rdata; ob_d_err = d_err; ob_conf = conflict_cnt;
      if (reset) begin
         p_iv = 0; p_dv = 0; p_de = 0; p_iw = 0; p_dd = 0; starve = 0; conf = 0;
      end else begin
         p_iv = egi;
         p_iw = rd_word(i_addr);
         p_dv = egd && !d_we;
         p_dd = (eiss && !d_we) ? load_val(d_funct3, d_addr) : 32'd0;
         p_de = egd && !dleg;
         if (i_req && d_req) conf = conf + 32'd1;
         if (!i_req || egi) starve = 0;
         else if (starve < LIMIT) starve++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
      step();
      g_d_ready = ob_d_ready; g_m_en = ob_m_en; g_m_addr = ob_m_addr;
      g_m_be = ob_m_be; g_m_wdata = ob_m_wdata;
      d_req = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
      d_funct3 = 0; d_wdata = 0;
      starve = 0; conf = 0; p_iv = 0; p_dv = 0; p_de = 0; p_iw = 0; p_dd = 0;
      for (int a = 0; a < 4096; a++) mem[a] <= 8'($urandom);

      // Reset: everything quiet even with requests pending
      i_req = 1; d_req = 1;
      repeat (3) step();
      chk("reset_m_en", {31'd0, ob_m_en}, 32'd0);
      i_req = 0; d_req = 0; reset = 1'b0;
      step();

      // Fetch only
      poke_word(12'h100, 32'h0050_0093);
      i_req = 1; i_addr = 32'h100;
      step();
      chk("t1_ready", {31'd0, ob_i_ready}, 32'd1);
      chk("t1_addr", ob_m_addr, 32'h100);
      i_req = 0;
      step();
      chk("t1_rdata", ob_i_rdata, 32'h0050_0093);

      // Contention: D,D,D,D,I repeating
      reset = 1; step(); reset = 0;
      i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h104;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t2_grant_d", {31'd0, ob_d_ready}, (k % 5 != 4) ? 32'd1 : 32'd0);
         if (k == 5) chk("t2_conflicts", ob_conf, 32'd5);
      end
      i_req = 0; d_req = 0;
      step();

      // Byte store lane steering
      do_data(1'b1, 3'd0, 32'h203, 32'h0000_00AB);
      chk("t3_be", {28'd0, g_m_be}, 32'h8);
      chk("t3_wdata", g_m_wdata, 32'hABAB_ABAB);
      chk("t3_addr", g_m_addr, 32'h200);
      chk("t3_no_rvalid", {31'd0, ob_d_rvalid}, 32'd0);

      // Load extraction and extension
      poke_word(12'h200, 32'h0000_F100);
      do_data(1'b0, 3'd0, 32'h201, 32'd0);
      chk("t4_lb", ob_d_rdata, 32'hFFFF_FFF1);
      do_data(1'b0, 3'd4, 32'h201, 32'd0);
      chk("t4_lbu", ob_d_rdata, 32'h0000_00F1);
      poke_word(12'h200, 32'h8001_1234);
      do_data(1'b0, 3'd1, 32'h202, 32'd0);
      chk("t4_lh", ob_d_rdata, 32'hFFFF_8001);

      // Misaligned accesses are consumed and flagged
      do_data(1'b0, 3'd2, 32'h102, 32'd0);
      chk("t5_lw_m_en", {31'd0, g_m_en}, 32'd0);
      chk("t5_lw_ready", {31'd0, g_d_ready}, 32'd1);
      chk("t5_lw_err", {31'd0, ob_d_err}, 32'd1);
      chk("t5_lw_rvalid", {31'd0, ob_d_rvalid}, 32'd1);
      do_data(1'b1, 3'd1, 32'h101, 32'h1234);
      chk("t5_sh_m_en", {31'd0, g_m_en}, 32'd0);
      chk("t5_sh_err", {31'd0, ob_d_err}, 32'd1);

      // Reset in the response cycle discards the load
      d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h100;
      step();
      d_req = 0; reset = 1;
      step();
      chk("t6_no_rvalid", {31'd0, ob_d_rvalid}, 32'd0);
      step();
      reset = 0;
      step();
      chk("t6_starve", {28'd0, dut.starve_cnt}, 32'd0);
      chk("t6_conflicts", ob_conf, 32'd0);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         if (!i_req && $urandom_range(0, 2) != 0) begin
            i_req = 1; i_addr = 32'($urandom_range(0, 4095));
         end
         if (!d_req && $urandom_range(0, 2) != 0) begin
            d_req = 1; d_we = ($urandom_range(0, 2) == 0);
            d_funct3 = 3'($urandom_range(0, 7));
            d_addr = 32'($urandom_range(0, 4095)); d_wdata = $urandom;
         end
         reset = ($urandom_range(0, 79) == 0);
         step();
         if (ob_i_ready) i_req = 0;
         if (ob_d_ready) d_req = 0;
      end
      reset = 0; i_req = 0; d_req = 0;
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported, byte-addressed unified memory between the CPU's instruction-fetch port and data load/store port.
- Data has priority, with a starvation limit so fetch always makes progress.
- Issues at most one memory access per cycle; read data returns one cycle later.
- Generates byte enables and lane steering from funct3 and address.
- Flags misaligned or illegal data accesses, and counts contention cycles for CPI analysis.

Parameters:
STARVE_LIMIT, 4, consecutive cycles fetch may lose arbitration before it is forcibly granted (1..15)
CNT_W, 32, width of contention counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  fetch request; addr held stable until i_ready
i_addr  in  32  fetch byte address; bits[1:0] ignored
i_ready  out  1  fetch request accepted this cycle (combinational)
i_rvalid  out  1  fetch data valid (cycle after acceptance)
i_rdata  out  32  fetch instruction word
d_req  in  1  data request; all d_* inputs held stable until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_funct3  in  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
d_wdata  in  32  store data, LSB-justified
d_ready  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  load result valid (cycle after acceptance); never for stores
d_rdata  out  32  aligned, sign/zero-extended load result
d_err  out  1  pulse, cycle after acceptance of a misaligned or illegal-funct3 request
m_en  out  1  memory access strobe
m_we  out  1  memory write
m_be  out  4  byte enables, bit i = byte lane i
m_addr  out  32  word address (bits[1:0]=0)
m_wdata  out  32  lane-steered store data
m_rdata  in  32  memory read word, valid one cycle after m_en && !m_we
conflict_cnt  out  CNT_W  cycles with i_req && d_req both high

Behaviour:
- Reset values: all outputs 0; starve_cnt=0; resp_valid=0; conflict_cnt=0.
- Arbitration (combinational, per cycle):
  - Only d_req: grant D. Only i_req: grant I.
  - Both: grant I if starve_cnt==STARVE_LIMIT, else grant D.
- Starvation counter:
  - Increments when i_req && !grant_I, saturating at STARVE_LIMIT.
  - Clears on grant_I or !i_req.
- Ready signals: i_ready=grant_I, d_ready=grant_D. A misaligned or illegal D request is still granted (consumed), but with m_en=0.
- Memory drive when a request is granted and legal:
  - m_en=1.
  - m_addr={addr[31:2],2'b00}.
  - Fetch: m_we=0, m_be=4'hF.
- Data alignment rules:
  - Word: addr[1:0]==0.
  - Half: addr[0]==0.
  - Byte: any address.
  - funct3 3'b011/110/111 is illegal. Store funct3 must be 000/001/010.
- Store lanes:
  - SB: m_be=1<<addr[1:0], wdata[7:0] replicated ×4.
  - SH: m_be=4'b0011<<addr[1:0], wdata[15:0] replicated ×2.
  - SW: m_be=4'hF.
- Response pipeline: registered owner {NONE,I,D}, offset[1:0] and funct3 for each legal read issued.
  - Next cycle, owner I: i_rvalid=1, i_rdata=m_rdata.
  - Next cycle, owner D load: d_rvalid=1, d_rdata extracted from lane offset. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Back-to-back accesses: a new grant may issue in the same cycle a response returns (full throughput, 1 access/cycle).
- Errors:
  - Error request: d_err=1 the following cycle.
  - If it was a load, d_rvalid=1 with d_rdata=0 in that same cycle. A store is dropped (no memory write).
- Inactive outputs: i_rdata/d_rdata are 0 when the matching rvalid is 0.
- conflict_cnt increments every cycle i_req&&d_req and wraps at 2^CNT_W.
- Reset mid-operation: an in-flight read is discarded (no rvalid after reset). A request presented in a cycle with reset=1 is not granted (ready=0, m_en=0).

Decomposition:
- Package mem_arb_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Owner enum {OWN_NONE, OWN_I, OWN_D}.
  - Functions: be_gen(funct3, off), is_aligned(funct3, off).
- One sub-module, mem_lane_align: purely combinational store-lane steering plus load extract/extend. It is shared by the arbiter and reusable by the bench's memory model.
- The FSM, counters and response pipeline live in unified_mem_arbiter.

Test Plan:
1. Fetch only, i_addr=0x100, memory word 0x00500093 → i_ready same cycle, m_addr=0x100, m_be=F; next cycle i_rvalid=1, i_rdata=0x00500093.
2. Both request continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeats; conflict_cnt=5 after 5 cycles.
3. SB d_addr=0x203, d_wdata=0x000000AB → m_be=4'b1000, m_wdata=0xABABABAB, m_addr=0x200; no d_rvalid.
4. LB at 0x201 with word 0x0000F100 → d_rdata=0xFFFFFFF1; LBU at the same address → 0x000000F1; LH at 0x202 with word 0x8001xxxx → 0xFFFF8001.
5. LW d_addr=0x102 → m_en=0, d_ready=1; next cycle d_err=1, d_rvalid=1, d_rdata=0. SH at 0x101 → no write, d_err pulse.
6. Load issued, reset asserted in the response cycle → no d_rvalid; all outputs 0; starve_cnt and conflict_cnt equal 0 after reset.
